// File: rtl/ps2_key_pkg.sv
// Shared types and scan-code constants for the PS/2 key sequencer.
package ps2_key_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_POP,
        S_GAP,
        S_DEC
    } seq_state_t;

    localparam logic [7:0] PS2_EXT  = 8'hE0;
    localparam logic [7:0] PS2_BRK  = 8'hF0;
    localparam logic [7:0] PS2_ERR0 = 8'h00;
    localparam logic [7:0] PS2_ERR1 = 8'hFF;

endpackage

// File: rtl/ps2_key_sequencer.sv
// Pops bytes from the PS/2 receiver FIFO, parses E0/F0 prefixes,
// tracks the held key and counts presses.
module ps2_key_sequencer
    import ps2_key_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx_ready,
    input  logic [7:0]       rx_data,
    input  logic             rx_overflow,
    output logic             rx_next_n,
    input  logic             clr_err,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic             key_held,
    output logic [CNT_W-1:0] press_cnt,
    output logic             evt_make,
    output logic             evt_break,
    output logic             err_overflow
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    seq_state_t       state, state_d;
    logic [7:0]       byte_q, byte_d;
    logic             pend_ext, pend_ext_d;
    logic             pend_brk, pend_brk_d;
    logic [TMO_W-1:0] tmo_cnt, tmo_d;
    logic             next_n_d;
    logic [7:0]       code_d;
    logic             ext_d, held_d;
    logic [CNT_W-1:0] cnt_d;
    logic             make_d, brk_d, err_d;
    logic             is_data, same_key;

    assign is_data  = (byte_q != PS2_EXT) && (byte_q != PS2_BRK) &&
                      (byte_q != PS2_ERR0) && (byte_q != PS2_ERR1);
    assign same_key = key_held && (byte_q == key_code) &&
                      (pend_ext == key_ext);

    always_comb begin
        state_d    = state;
        byte_d     = byte_q;
        pend_ext_d = pend_ext;
        pend_brk_d = pend_brk;
        tmo_d      = tmo_cnt;
        next_n_d   = 1'b1;
        code_d     = key_code;
        ext_d      = key_ext;
        held_d     = key_held;
        cnt_d      = press_cnt;
        make_d     = 1'b0;
        brk_d      = 1'b0;
        err_d      = err_overflow;
        if (clr_err)
            err_d = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (rx_ready) begin
                    byte_d   = rx_data;
                    next_n_d = 1'b0;
                    tmo_d    = '0;
                    state_d  = S_POP;
                end else if (pend_ext || pend_brk) begin
                    if (tmo_cnt == TMO_LAST) begin
                        pend_ext_d = 1'b0;
                        pend_brk_d = 1'b0;
                        tmo_d      = '0;
                    end else begin
                        tmo_d = tmo_cnt + 1'b1;
                    end
                end
            end
            S_POP: state_d = S_GAP;
            S_GAP: state_d = S_DEC;
            S_DEC: begin
                state_d = S_IDLE;
                unique case (1'b1)
                    byte_q == PS2_EXT: pend_ext_d = 1'b1;
                    byte_q == PS2_BRK: pend_brk_d = 1'b1;
                    (byte_q == PS2_ERR0) || (byte_q == PS2_ERR1): begin
                        err_d      = 1'b1;
                        pend_ext_d = 1'b0;
                        pend_brk_d = 1'b0;
                    end
                    is_data && pend_brk: begin
                        if (same_key) begin
                            held_d = 1'b0;
                            brk_d  = 1'b1;
                        end
                        pend_ext_d = 1'b0;
                        pend_brk_d = 1'b0;
                    end
                    is_data && !pend_brk: begin
                        // a repeat of the held key is typematic, not a press
                        if (!same_key) begin
                            code_d = byte_q;
                            ext_d  = pend_ext;
                            held_d = 1'b1;
                            cnt_d  = press_cnt + 1'b1;
                            make_d = 1'b1;
                        end
                        pend_ext_d = 1'b0;
                        pend_brk_d = 1'b0;
                    end
                    default: ;
                endcase
            end
            default: state_d = S_IDLE;
        endcase
        // overflow wins over any prefix captured this cycle
        if (rx_overflow) begin
            err_d      = 1'b1;
            pend_ext_d = 1'b0;
            pend_brk_d = 1'b0;
            tmo_d      = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            byte_q       <= 8'h00;
            pend_ext     <= 1'b0;
            pend_brk     <= 1'b0;
            tmo_cnt      <= '0;
            rx_next_n    <= 1'b1;
            key_code     <= 8'h00;
            key_ext      <= 1'b0;
            key_held     <= 1'b0;
            press_cnt    <= '0;
            evt_make     <= 1'b0;
            evt_break    <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            state        <= state_d;
            byte_q       <= byte_d;
            pend_ext     <= pend_ext_d;
            pend_brk     <= pend_brk_d;
            tmo_cnt      <= tmo_d;
            rx_next_n    <= next_n_d;
            key_code     <= code_d;
            key_ext      <= ext_d;
            key_held     <= held_d;
            press_cnt    <= cnt_d;
            evt_make     <= make_d;
            evt_break    <= brk_d;
            err_overflow <= err_d;
        end
    end

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Directed bench for ps2_key_sequencer with a one-byte receiver model.
module tb_ps2_key_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_overflow;
    logic       rx_next_n;
    logic       clr_err;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_held;
    logic [7:0] press_cnt;
    logic       evt_make;
    logic       evt_break;
    logic       err_overflow;

    int checks = 0;
    int errors = 0;
    int mk_cnt = 0;
    int br_cnt = 0;
    int mk0, br0;

    ps2_key_sequencer #(
        .CNT_W(8),
        .TIMEOUT_CYC(10)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx_ready(rx_ready),
        .rx_data(rx_data),
        .rx_overflow(rx_overflow),
        .rx_next_n(rx_next_n),
        .clr_err(clr_err),
        .key_code(key_code),
        .key_ext(key_ext),
        .key_held(key_held),
        .press_cnt(press_cnt),
        .evt_make(evt_make),
        .evt_break(evt_break),
        .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (evt_make)
            mk_cnt <= mk_cnt + 1;
        if (evt_break)
            br_cnt <= br_cnt + 1;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // present one byte, wait for the pop, then let decode complete
    task automatic send(input logic [7:0] b);
        int n;
        rx_data  = b;
        rx_ready = 1'b1;
        n = 0;
        while (rx_next_n !== 1'b0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("pop_seen", int'(rx_next_n), 0);
        rx_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("pop_one_cycle", int'(rx_next_n), 1);
        idle(3);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_next_n"}, int'(rx_next_n), 1);
        chk({tag, "_code"}, int'(key_code), 0);
        chk({tag, "_ext"}, int'(key_ext), 0);
        chk({tag, "_held"}, int'(key_held), 0);
        chk({tag, "_cnt"}, int'(press_cnt), 0);
        chk({tag, "_make"}, int'(evt_make), 0);
        chk({tag, "_break"}, int'(evt_break), 0);
        chk({tag, "_err"}, int'(err_overflow), 0);
    endtask

    initial begin
        reset       = 1'b1;
        rx_ready    = 1'b0;
        rx_data     = 8'h00;
        rx_overflow = 1'b0;
        clr_err     = 1'b0;
        idle(3);
        check_reset_vals("rst");
        reset = 1'b0;
        idle(2);

        // simple make then break
        mk0 = mk_cnt;
        br0 = br_cnt;
        send(8'h1C);
        chk("mk1_code", int'(key_code), 'h1C);
        chk("mk1_held", int'(key_held), 1);
        chk("mk1_ext", int'(key_ext), 0);
        chk("mk1_cnt", int'(press_cnt), 1);
        chk("mk1_evt", mk_cnt - mk0, 1);
        send(8'hF0);
        send(8'h1C);
        chk("br1_held", int'(key_held), 0);
        chk("br1_evt", br_cnt - br0, 1);
        chk("br1_cnt", int'(press_cnt), 1);

        // typematic repeats
        mk0 = mk_cnt;
        br0 = br_cnt;
        send(8'h1C);
        send(8'h1C);
        send(8'h1C);
        chk("rep_cnt", int'(press_cnt), 2);
        chk("rep_mk", mk_cnt - mk0, 1);
        send(8'hF0);
        send(8'h1C);
        chk("rep_br", br_cnt - br0, 1);
        chk("rep_held", int'(key_held), 0);

        // extended key
        mk0 = mk_cnt;
        br0 = br_cnt;
        send(8'hE0);
        send(8'h75);
        chk("ext_code", int'(key_code), 'h75);
        chk("ext_ext", int'(key_ext), 1);
        chk("ext_cnt", int'(press_cnt), 3);
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        chk("ext_br_held", int'(key_held), 0);
        chk("ext_br", br_cnt - br0, 1);
        send(8'hE0);
        send(8'h75);
        chk("ext2_cnt", int'(press_cnt), 4);
        send(8'hF0);
        send(8'h75);
        chk("ext_nobrk_held", int'(key_held), 1);
        chk("ext_nobrk_br", br_cnt - br0, 1);
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        chk("ext_br2_held", int'(key_held), 0);
        chk("ext_mk_total", mk_cnt - mk0, 2);

        // prefix timeout
        send(8'hE0);
        idle(20);
        send(8'h1C);
        chk("tmo_ext", int'(key_ext), 0);
        chk("tmo_code", int'(key_code), 'h1C);
        chk("tmo_cnt", int'(press_cnt), 5);
        send(8'hE0);
        idle(3);
        send(8'h1C);
        chk("notmo_ext", int'(key_ext), 1);
        chk("notmo_cnt", int'(press_cnt), 6);
        br0 = br_cnt;
        send(8'hF0);
        send(8'h1C);
        chk("notmo_nobrk", int'(key_held), 1);
        send(8'hE0);
        send(8'hF0);
        send(8'h1C);
        chk("notmo_brk", br_cnt - br0, 1);
        chk("notmo_held", int'(key_held), 0);

        // overflow handling
        mk0 = mk_cnt;
        send(8'hF0);
        rx_overflow = 1'b1;
        idle(1);
        rx_overflow = 1'b0;
        chk("ovf_set", int'(err_overflow), 1);
        send(8'h1C);
        chk("ovf_make", mk_cnt - mk0, 1);
        chk("ovf_held", int'(key_held), 1);
        chk("ovf_cnt", int'(press_cnt), 7);
        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;
        chk("ovf_clr", int'(err_overflow), 0);
        send(8'hFF);
        chk("err_ff", int'(err_overflow), 1);
        chk("err_ff_nomk", mk_cnt - mk0, 1);
        chk("err_ff_cnt", int'(press_cnt), 7);
        clr_err = 1'b1;
        idle(1);
        chk("clr2", int'(err_overflow), 0);
        rx_overflow = 1'b1;
        idle(1);
        rx_overflow = 1'b0;
        clr_err = 1'b0;
        chk("set_wins", int'(err_overflow), 1);
        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;
        send(8'hF0);
        send(8'h1C);
        chk("ovf_rel", int'(key_held), 0);

        // press counter wrap
        mk0 = mk_cnt;
        for (int i = 0; i < 249; i++) begin
            send(8'h01 + 8'(i % 'hD0));
            if (i == 248)
                chk("wrap_00", int'(press_cnt), 0);
            if (i == 247)
                chk("wrap_ff", int'(press_cnt), 'hFF);
            send(8'hF0);
            send(8'h01 + 8'(i % 'hD0));
        end
        chk("wrap_mk", mk_cnt - mk0, 249);
        chk("wrap_held", int'(key_held), 0);

        // reset while in the guard cycle
        send(8'h2A);
        chk("pre_rst_held", int'(key_held), 1);
        rx_data  = 8'h33;
        rx_ready = 1'b1;
        while (rx_next_n !== 1'b0) begin
            @(posedge clk);
            #1;
        end
        rx_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #2;
        check_reset_vals("mrst");
        idle(2);
        reset = 1'b0;
        mk0 = mk_cnt;
        idle(6);
        chk("mrst_discard", mk_cnt - mk0, 0);
        chk("mrst_cnt", int'(press_cnt), 0);
        send(8'h1C);
        chk("post_rst_cnt", int'(press_cnt), 1);
        chk("post_rst_code", int'(key_code), 'h1C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
